// File: rtl/led_pwm_fader.sv
`default_nettype none
// ============================================================================
// led_pwm_fader: PWM LED driver that fades linearly toward a runtime ceiling.
// Revision: 1.0
// ============================================================================
module led_pwm_fader #(
  parameter int PWM_BITS         = 8,
  parameter int RAMP_STEP_CYCLES = 98039,
  parameter bit INVERT           = 1'b0
) (
  input  logic                fpga_clk_50,
  input  logic                hps_fpga_reset_n,
  input  logic                led_in,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] max_duty,
  output logic                LED,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam int STEP_W = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(RAMP_STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_next;
  logic [STEP_W-1:0]   step_cnt;
  logic [STEP_W-1:0]   step_next;
  logic                step_tick;
  logic                busy_next;

  assign step_tick = (step_cnt == STEP_LAST);

  // step_next defaults to zero so any state change or idle state clears it.
  always_comb begin
    state_next = state;
    duty_next  = duty;
    step_next  = '0;
    if (!enable) begin
      state_next = OFF;
      duty_next  = '0;
    end else begin
      case (state)
        OFF: begin
          duty_next = '0;
          if (led_in) state_next = RAMP_UP;
        end
        RAMP_UP: begin
          if (!led_in) begin
            state_next = RAMP_DOWN;
          end else if (duty >= max_duty) begin
            state_next = ON;
            duty_next  = max_duty;
          end else if (step_tick) begin
            if (duty != DUTY_FULL) duty_next = duty + 1'b1;
          end else begin
            step_next = step_cnt + 1'b1;
          end
        end
        ON: begin
          duty_next = max_duty;
          if (!led_in) state_next = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (led_in) begin
            state_next = RAMP_UP;
          end else if (duty == '0) begin
            state_next = OFF;
          end else if (step_tick) begin
            duty_next = duty - 1'b1;
          end else begin
            step_next = step_cnt + 1'b1;
          end
        end
        default: state_next = OFF;
      endcase
    end
    busy_next = (state_next == RAMP_UP) || (state_next == RAMP_DOWN);
  end

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      state    <= OFF;
      duty     <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      duty     <= duty_next;
      step_cnt <= step_next;
      busy     <= busy_next;
    end
  end

  // Output is registered so the pin sees a glitch-free PWM waveform.
  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      pwm_cnt <= '0;
      LED     <= INVERT;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      LED     <= (pwm_cnt < duty) ^ INVERT;
    end
  end

endmodule
`default_nettype wire
